serial_bus_master: RTL and testbench

//  Host-side debug loader. Takes a received byte stream (from the UART receive path) as

---
 rtl/serial_bus_master.sv | 223 ++++++++++++++++++++++
 tb/tb_serial_bus_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_master.sv
// Debug loader: parses W/R command frames from the receive byte stream, masters the CPU
// memory bus via bus_req/bus_gnt, and returns reply bytes on the transmit byte stream.
module serial_bus_master #(
  parameter int ASIZE  = 16,
  parameter int DSIZE  = 16,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [ASIZE-1:0] address,
  output logic [DSIZE-1:0] dout,
  input  logic [DSIZE-1:0] din,
  output logic             rnw,
  output logic             vda
);
  localparam int ABYTES = (ASIZE + 7) / 8;
  localparam int DBYTES = DSIZE / 8;
  localparam logic [7:0] ALAST    = 8'(ABYTES - 1);
  localparam logic [7:0] DLAST    = 8'(DBYTES - 1);
  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);
  localparam logic [7:0] CMD_W    = 8'h57;
  localparam logic [7:0] CMD_R    = 8'h52;
  localparam logic [7:0] RPL_ACK  = 8'h2B;
  localparam logic [7:0] RPL_ERR  = 8'h3F;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_COUNT, S_GRANT, S_WDATA, S_WACC,
    S_RACC, S_RWAIT, S_RSEND, S_REPLY, S_ERR
  } state_t;

  state_t           state_reg;
  logic             is_read_reg;
  logic             have_word_reg;
  logic [ASIZE-1:0] addr_reg;
  logic [DSIZE-1:0] wdata_reg;
  logic [DSIZE-1:0] rshift_reg;
  logic [8:0]       words_reg;
  logic [7:0]       byte_cnt_reg;
  logic [1:0]       lat_cnt_reg;
  logic             rx_ready_reg;
  logic [7:0]       tx_data_reg;
  logic             tx_valid_reg;
  logic             bus_req_reg;
  logic [ASIZE-1:0] address_reg;
  logic [DSIZE-1:0] dout_reg;
  logic             rnw_reg;
  logic             vda_reg;

  logic             take;
  logic [DSIZE-1:0] wdata_next;

  assign take       = rx_valid & rx_ready_reg;
  assign wdata_next = DSIZE'({wdata_reg, rx_data});

  assign rx_ready = rx_ready_reg;
  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign bus_req  = bus_req_reg;
  assign address  = address_reg;
  assign dout     = dout_reg;
  assign rnw      = rnw_reg;
  assign vda      = vda_reg;

  // addr_reg is the running word pointer; address_reg only changes when an access starts,
  // so the bus address holds steady between strobes.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_reg     <= S_IDLE;
      is_read_reg   <= 1'b0;
      have_word_reg <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rshift_reg    <= '0;
      words_reg     <= '0;
      byte_cnt_reg  <= '0;
      lat_cnt_reg   <= '0;
      rx_ready_reg  <= 1'b0;
      tx_data_reg   <= '0;
      tx_valid_reg  <= 1'b0;
      bus_req_reg   <= 1'b0;
      address_reg   <= '0;
      dout_reg      <= '0;
      rnw_reg       <= 1'b1;
      vda_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          rx_ready_reg <= 1'b1;
          if (take) begin
            byte_cnt_reg <= '0;
            if (rx_data == CMD_W || rx_data == CMD_R) begin
              is_read_reg <= (rx_data == CMD_R);
              state_reg   <= S_ADDR;
            end else begin
              rx_ready_reg <= 1'b0;
              tx_data_reg  <= RPL_ERR;
              tx_valid_reg <= 1'b1;
              state_reg    <= S_ERR;
            end
          end
        end
        S_ADDR: if (take) begin
          addr_reg <= ASIZE'({addr_reg, rx_data});
          if (byte_cnt_reg == ALAST) state_reg <= S_COUNT;
          else byte_cnt_reg <= byte_cnt_reg + 8'd1;
        end
        S_COUNT: if (take) begin
          words_reg     <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          have_word_reg <= 1'b0;
          bus_req_reg   <= 1'b1;
          rx_ready_reg  <= 1'b0;
          state_reg     <= S_GRANT;
        end
        // Every access is launched only from a cycle where the grant was seen.
        S_GRANT: if (bus_gnt) begin
          if (is_read_reg) begin
            address_reg <= addr_reg;
            rnw_reg     <= 1'b1;
            vda_reg     <= 1'b1;
            state_reg   <= S_RACC;
          end else if (have_word_reg) begin
            address_reg <= addr_reg;
            dout_reg    <= wdata_reg;
            rnw_reg     <= 1'b0;
            vda_reg     <= 1'b1;
            state_reg   <= S_WACC;
          end else begin
            rx_ready_reg <= 1'b1;
            byte_cnt_reg <= '0;
            state_reg    <= S_WDATA;
          end
        end
        S_WDATA: if (take) begin
          wdata_reg <= wdata_next;
          if (byte_cnt_reg == DLAST) begin
            rx_ready_reg <= 1'b0;
            if (bus_gnt) begin
              address_reg <= addr_reg;
              dout_reg    <= wdata_next;
              rnw_reg     <= 1'b0;
              vda_reg     <= 1'b1;
              state_reg   <= S_WACC;
            end else begin
              have_word_reg <= 1'b1;
              state_reg     <= S_GRANT;
            end
          end else begin
            byte_cnt_reg <= byte_cnt_reg + 8'd1;
          end
        end
        S_WACC: begin
          vda_reg       <= 1'b0;
          rnw_reg       <= 1'b1;
          have_word_reg <= 1'b0;
          addr_reg      <= addr_reg + ASIZE'(1);
          words_reg     <= words_reg - 9'd1;
          if (words_reg == 9'd1) begin
            bus_req_reg  <= 1'b0;
            tx_data_reg  <= RPL_ACK;
            tx_valid_reg <= 1'b1;
            state_reg    <= S_REPLY;
          end else begin
            rx_ready_reg <= 1'b1;
            byte_cnt_reg <= '0;
            state_reg    <= S_WDATA;
          end
        end
        S_RACC: begin
          vda_reg     <= 1'b0;
          lat_cnt_reg <= LAT_LOAD;
          state_reg   <= S_RWAIT;
        end
        S_RWAIT: begin
          if (lat_cnt_reg == 2'd0) begin
            tx_data_reg  <= din[DSIZE-1 -: 8];
            rshift_reg   <= din << 8;
            tx_valid_reg <= 1'b1;
            byte_cnt_reg <= '0;
            addr_reg     <= addr_reg + ASIZE'(1);
            words_reg    <= words_reg - 9'd1;
            if (words_reg == 9'd1) bus_req_reg <= 1'b0;
            state_reg    <= S_RSEND;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 2'd1;
          end
        end
        S_RSEND: if (tx_ready) begin
          if (byte_cnt_reg == DLAST) begin
            tx_valid_reg <= 1'b0;
            if (words_reg == 9'd0) begin
              rx_ready_reg <= 1'b1;
              state_reg    <= S_IDLE;
            end else if (bus_gnt) begin
              address_reg <= addr_reg;
              vda_reg     <= 1'b1;
              state_reg   <= S_RACC;
            end else begin
              state_reg <= S_GRANT;
            end
          end else begin
            tx_data_reg  <= rshift_reg[DSIZE-1 -: 8];
            rshift_reg   <= rshift_reg << 8;
            byte_cnt_reg <= byte_cnt_reg + 8'd1;
          end
        end
        S_REPLY, S_ERR: if (tx_ready) begin
          tx_valid_reg <= 1'b0;
          rx_ready_reg <= 1'b1;
          state_reg    <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_bus_master.sv
// Randomized frame-level bench for serial_bus_master: a memory-image reference model
// predicts bus accesses and reply bytes, checked against a RAM responder and tx monitor.
module tb_serial_bus_master;
  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [15:0] address;
  logic [15:0] dout;
  logic [15:0] din = 16'h0000;
  logic        rnw;
  logic        vda;

  serial_bus_master #(.ASIZE(16), .DSIZE(16), .RD_LAT(1)) dut (
    .clk(clk), .reset_b(reset_b),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .address(address), .dout(dout), .din(din),
    .rnw(rnw), .vda(vda)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fails = 0;
  int          cyc = 0;
  logic [15:0] ram     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [31:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  rx_q[$];
  logic [15:0] noq[$];
  logic [15:0] t1w[$];
  logic        rx_take_pend = 1'b0;
  int          gnt_low_until = 0;
  int          drop_until = 0;
  bit          drop_mode = 1'b0;
  int          tx_rate = 1;
  int          rx_rate = 1;
  logic [15:0] rd_pipe = 16'h0000;
  logic        rd_pipe_v = 1'b0;
  logic        prev_tx_pend = 1'b0;
  logic [7:0]  prev_tx_data = 8'h00;
  bit          saw_req = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  endtask

  // One clock of bench activity, run at the falling edge: observe, then drive.
  task automatic tick();
    logic hs;
    @(negedge clk);
    cyc++;
    if (bus_req) saw_req = 1'b1;
    if (rx_take_pend) void'(rx_q.pop_front());
    // Read data is valid only in the cycle where RD_LAT=1 capture happens.
    din = rd_pipe_v ? rd_pipe : 16'($urandom);
    rd_pipe_v = 1'b0;
    if (vda) begin
      check_val("vda_gnt", 32'(bus_gnt), 32'd1);
      if (rnw) begin
        check_val("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) check_val("rd_addr", 32'(address), 32'(exp_rd.pop_front()));
        rd_pipe   = ram[address];
        rd_pipe_v = 1'b1;
      end else begin
        check_val("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
        if (exp_wr.size() > 0) check_val("wr_addr_data", {address, dout}, exp_wr.pop_front());
        ram[address] = dout;
      end
      if (drop_mode) drop_until = cyc + 10;
    end
    if (prev_tx_pend) check_val("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, prev_tx_data}));
    tx_ready = ($urandom_range(tx_rate - 1) == 0);
    hs = tx_valid && tx_ready;
    if (hs) begin
      check_val("tx_expected", 32'(exp_tx.size() > 0), 32'd1);
      if (exp_tx.size() > 0) check_val("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
    end
    prev_tx_pend = tx_valid && !tx_ready;
    prev_tx_data = tx_data;
    bus_gnt = (cyc >= gnt_low_until) && (cyc >= drop_until);
    if (rx_q.size() > 0 && $urandom_range(rx_rate - 1) == 0) begin
      rx_valid = 1'b1;
      rx_data  = rx_q[0];
    end else begin
      rx_valid = 1'b0;
    end
    rx_take_pend = rx_valid && rx_ready;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((rx_q.size() > 0 || exp_wr.size() > 0 || exp_rd.size() > 0 || exp_tx.size() > 0)
           && n < 6000) begin
      tick();
      n++;
    end
    check_val({tag, "_done"}, 32'(n < 6000), 32'd1);
    if (n >= 6000) finish_run();
    repeat (3) tick();
    check_val({tag, "_req_off"}, 32'(bus_req), 32'd0);
    check_val({tag, "_rx_rdy"}, 32'(rx_ready), 32'd1);
  endtask

  // Reference model: frame semantics applied to a flat memory image.
  task automatic do_frame(input string tag, input logic [7:0] cmd, input logic [15:0] addr,
                          input logic [7:0] cnt, input logic [15:0] words[$]);
    int n = (cnt == 8'd0) ? 256 : int'(cnt);
    logic [15:0] a;
    logic [15:0] w;
    rx_q.push_back(cmd);
    if (cmd == 8'h57 || cmd == 8'h52) begin
      rx_q.push_back(addr[15:8]);
      rx_q.push_back(addr[7:0]);
      rx_q.push_back(cnt);
      for (int i = 0; i < n; i++) begin
        a = addr + 16'(i);
        if (cmd == 8'h57) begin
          w = (i < words.size()) ? words[i] : 16'($urandom);
          rx_q.push_back(w[15:8]);
          rx_q.push_back(w[7:0]);
          exp_wr.push_back({a, w});
          ref_mem[a] = w;
        end else begin
          w = ref_mem[a];
          exp_rd.push_back(a);
          exp_tx.push_back(w[15:8]);
          exp_tx.push_back(w[7:0]);
        end
      end
      if (cmd == 8'h57) exp_tx.push_back(8'h2B);
    end else begin
      exp_tx.push_back(8'h3F);
    end
    wait_done(tag);
    $display("%s: cmd=%02h addr=%04h count=%0d cycle=%0d", tag, cmd, addr, cnt, cyc);
  endtask

  initial begin
    logic [7:0]  cmd;
    logic [15:0] addr;
    int          r;
    int          n;
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 16'($urandom);
      ref_mem[i] = ram[i];
    end
    t1w = {16'h1234, 16'hABCD};

    repeat (3) tick();
    check_val("rst_bus_req", 32'(bus_req), 32'd0);
    check_val("rst_vda", 32'(vda), 32'd0);
    check_val("rst_rnw", 32'(rnw), 32'd1);
    check_val("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_val("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_val("rst_addr_dout", {address, dout}, 32'd0);
    #3 reset_b = 1'b1;
    tick();
    check_val("rx_ready_after_rst", 32'(rx_ready), 32'd1);

    do_frame("T1", 8'h57, 16'h0100, 8'd2, t1w);
    do_frame("T2", 8'h52, 16'h0100, 8'd2, noq);
    saw_req = 1'b0;
    do_frame("T3", 8'h41, 16'h0000, 8'd0, noq);
    check_val("T3_no_req", 32'(saw_req), 32'd0);
    do_frame("T3b", 8'h52, 16'h0100, 8'd2, noq);
    do_frame("T4", 8'h57, 16'hFFFF, 8'd0, noq);
    do_frame("T4r", 8'h52, 16'hFFF0, 8'd32, noq);

    gnt_low_until = cyc + 20;
    tx_rate   = 4;
    drop_mode = 1'b1;
    do_frame("T5w", 8'h57, 16'h2000, 8'd5, noq);
    gnt_low_until = cyc + 20;
    do_frame("T5r", 8'h52, 16'h2000, 8'd5, noq);
    tx_rate   = 1;
    drop_mode = 1'b0;

    // Reset right after the first word's strobe; only that write may reach memory.
    rx_q = {8'h57, 8'h01, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    exp_wr.push_back({16'h0100, 16'h1234});
    ref_mem[16'h0100] = 16'h1234;
    n = 0;
    while (rx_q.size() > 2 && n < 200) begin
      tick();
      n++;
    end
    check_val("T6_reached", 32'(n < 200), 32'd1);
    #2 reset_b = 1'b0;
    #1;
    check_val("T6_bus_req", 32'(bus_req), 32'd0);
    check_val("T6_vda", 32'(vda), 32'd0);
    check_val("T6_rnw", 32'(rnw), 32'd1);
    check_val("T6_tx_valid", 32'(tx_valid), 32'd0);
    check_val("T6_rx_ready", 32'(rx_ready), 32'd0);
    check_val("T6_wr_done", 32'(exp_wr.size()), 32'd0);
    rx_q.delete();
    exp_wr.delete();
    rx_take_pend = 1'b0;
    rx_valid     = 1'b0;
    prev_tx_pend = 1'b0;
    tick();
    #3 reset_b = 1'b1;
    tick();
    $display("T6: reset mid-frame at cycle %0d", cyc);
    do_frame("T6w", 8'h57, 16'h0100, 8'd2, t1w);
    do_frame("T6r", 8'h52, 16'h0100, 8'd2, noq);

    for (int k = 0; k < 25; k++) begin
      r = $urandom_range(9);
      if (r < 5) cmd = 8'h57;
      else if (r < 9) cmd = 8'h52;
      else begin
        cmd = 8'($urandom);
        if (cmd == 8'h57 || cmd == 8'h52) cmd = 8'h00;
      end
      addr = ($urandom_range(3) == 0) ? 16'hFFFF - 16'($urandom_range(4)) : 16'($urandom);
      rx_rate   = $urandom_range(3, 1);
      tx_rate   = $urandom_range(3, 1);
      drop_mode = ($urandom_range(2) == 0);
      do_frame("RND", cmd, addr, 8'($urandom_range(6, 1)), noq);
    end
    finish_run();
  end
endmodule
